mem_arbiter: RTL and testbench

Single-port memory arbiter between the IF stage (instruction fetch) and the MEM stage (load/store). It serializes both requesters onto one word-wide memory port and sequences each transaction with a request/acknowledge handshake. It produces `InstMem_Ready` and `MEM_Stall_Controller`, which Hazard_Detection consumes to stall the pipeline. Data accesses have priority over fetches; a started transaction is never preempted.

---
 rtl/mem_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Purpose: shares one word-wide memory port between the IF stage (fetch) and
// the MEM stage (load/store). Data accesses win over fetches in IDLE. Once a
// transaction starts, it runs to Mem_Ack and is never preempted. Every
// transaction is followed by exactly one IDLE cycle.
//
// Handshake: a requester holds its read/write level high until it sees its
// Ready level and pulses Advance, or until it drops the request (flush).
// Toward memory, Mem_Req stays high with stable Addr/WE/WriteData until the
// cycle in which Mem_Ack is sampled high. Mem_ReadData is valid in that cycle.
//
// Ports:
//   clock, reset          clock; synchronous active-low reset
//   InstMem_*, IF_Advance fetch request / result / consume
//   MEM_*, DataMem_*      load-store request / result / consume
//   MEM_Stall_Controller  data request pending and not yet complete
//   Mem_*                 memory-side transaction port
//   Mem_Timeout           one-cycle abort pulse (optional feature)
//   state_dbg             current FSM state (IDLE=0, DATA=1, INST=2)
//
// Optional feature: define MEMARB_TIMEOUT_EN to abort a transaction after
// TIMEOUT busy cycles without Mem_Ack. When the macro is undefined, Mem_Timeout
// is tied low and the block waits indefinitely.
// -----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int TIMEOUT = 255
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        InstMem_Read,
   input  logic [29:0] InstMem_Address,
   input  logic        IF_Advance,
   output logic        InstMem_Ready,
   output logic [31:0] InstMem_Data,
   input  logic        MEM_MemRead,
   input  logic        MEM_MemWrite,
   input  logic [29:0] MEM_Address,
   input  logic [31:0] MEM_WriteData,
   input  logic [3:0]  MEM_ByteEn,
   input  logic        MEM_Advance,
   output logic        DataMem_Ready,
   output logic [31:0] DataMem_ReadData,
   output logic        MEM_Stall_Controller,
   output logic        Mem_Req,
   output logic [29:0] Mem_Addr,
   output logic [3:0]  Mem_WE,
   output logic [31:0] Mem_WriteData,
   input  logic        Mem_Ack,
   input  logic [31:0] Mem_ReadData,
   output logic        Mem_Timeout,
   output logic [1:0]  state_dbg
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      INST = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic        d_served, d_served_nxt;
   logic        i_served, i_served_nxt;
   logic [31:0] d_data, d_data_nxt;
   logic [31:0] i_data, i_data_nxt;
   logic [29:0] lat_addr, lat_addr_nxt;
   logic [3:0]  lat_we, lat_we_nxt;
   logic [31:0] lat_wdata, lat_wdata_nxt;
   logic        lat_write, lat_write_nxt;

   logic        d_req, i_req;
   logic        d_pend, i_pend;
   logic        abort;

   assign d_req  = MEM_MemRead | MEM_MemWrite;
   assign i_req  = InstMem_Read;
   assign d_pend = d_req & ~d_served;
   assign i_pend = i_req & ~i_served;

`ifdef MEMARB_TIMEOUT_EN
   // The counter is at least 8 bits wide and grows if TIMEOUT needs more bits.
   localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
   logic [CW-1:0] to_cnt;

   // The counter is held at zero in IDLE, so it starts from zero in the first
   // busy cycle.
   always_ff @(posedge clock) begin
      if (!reset) begin
         to_cnt <= '0;
      end else if (state == IDLE) begin
         to_cnt <= '0;
      end else if (!Mem_Ack) begin
         to_cnt <= to_cnt + CW'(1);
      end
   end

   // If the ack arrives in the limit cycle, the ack wins over the abort.
   assign abort       = (state != IDLE) & ~Mem_Ack & (to_cnt == CW'(TIMEOUT));
   assign Mem_Timeout = abort;
`else
   assign abort       = 1'b0;
   assign Mem_Timeout = 1'b0;
`endif

   // State and datapath registers
   always_ff @(posedge clock) begin
      if (!reset) begin
         state     <= IDLE;
         d_served  <= 1'b0;
         i_served  <= 1'b0;
         d_data    <= '0;
         i_data    <= '0;
         lat_addr  <= '0;
         lat_we    <= '0;
         lat_wdata <= '0;
         lat_write <= 1'b0;
      end else begin
         state     <= state_nxt;
         d_served  <= d_served_nxt;
         i_served  <= i_served_nxt;
         d_data    <= d_data_nxt;
         i_data    <= i_data_nxt;
         lat_addr  <= lat_addr_nxt;
         lat_we    <= lat_we_nxt;
         lat_wdata <= lat_wdata_nxt;
         lat_write <= lat_write_nxt;
      end
   end

   // Next-state logic and served-flag logic
   always_comb begin
      state_nxt     = state;
      d_data_nxt    = d_data;
      i_data_nxt    = i_data;
      lat_addr_nxt  = lat_addr;
      lat_we_nxt    = lat_we;
      lat_wdata_nxt = lat_wdata;
      lat_write_nxt = lat_write;

      // A result is held until it is consumed or until its request goes away.
      d_served_nxt  = d_served & d_req & ~MEM_Advance;
      i_served_nxt  = i_served & i_req & ~IF_Advance;

      case (state)
         IDLE: begin
            if (d_pend) begin
               state_nxt     = DATA;
               lat_addr_nxt  = MEM_Address;
               lat_wdata_nxt = MEM_WriteData;
               lat_write_nxt = MEM_MemWrite;
               lat_we_nxt    = MEM_MemWrite ? MEM_ByteEn : 4'b0000;
            end else if (i_pend) begin
               state_nxt     = INST;
               lat_addr_nxt  = InstMem_Address;
               lat_wdata_nxt = '0;
               lat_write_nxt = 1'b0;
               lat_we_nxt    = 4'b0000;
            end
         end

         DATA: begin
            // If the request was dropped (flush), the result is discarded.
            // A store completes the access but leaves the load data untouched.
            // An ack in the same cycle as MEM_Advance sets the flag (ack wins).
            if (Mem_Ack) begin
               state_nxt = IDLE;
               if (d_req) begin
                  d_served_nxt = 1'b1;
                  if (!lat_write) d_data_nxt = Mem_ReadData;
               end
            end else if (abort) begin
               state_nxt = IDLE;
               if (d_req) begin
                  d_served_nxt = 1'b1;
                  d_data_nxt   = '0;
               end
            end
         end

         INST: begin
            if (Mem_Ack) begin
               state_nxt = IDLE;
               if (i_req) begin
                  i_served_nxt = 1'b1;
                  i_data_nxt   = Mem_ReadData;
               end
            end else if (abort) begin
               state_nxt = IDLE;
               if (i_req) begin
                  i_served_nxt = 1'b1;
                  i_data_nxt   = '0;
               end
            end
         end

         default: state_nxt = IDLE;
      endcase
   end

   assign InstMem_Ready        = i_served;
   assign InstMem_Data         = i_data;
   assign DataMem_Ready        = d_served;
   assign DataMem_ReadData     = d_data;
   // The stall is gated by reset, so every output reads 0 while reset is held.
   assign MEM_Stall_Controller = d_pend & reset;
   assign Mem_Req              = (state != IDLE);
   assign Mem_Addr             = lat_addr;
   assign Mem_WE               = lat_we;
   assign Mem_WriteData        = lat_wdata;
   assign state_dbg            = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter. The bench drives the memory side by hand
// (Mem_Ack / Mem_ReadData), so every latency below is explicit. Inputs change
// 1 time unit after the rising edge. Outputs are sampled after that.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

   logic        clock;
   logic        reset;
   logic        InstMem_Read;
   logic [29:0] InstMem_Address;
   logic        IF_Advance;
   logic        InstMem_Ready;
   logic [31:0] InstMem_Data;
   logic        MEM_MemRead;
   logic        MEM_MemWrite;
   logic [29:0] MEM_Address;
   logic [31:0] MEM_WriteData;
   logic [3:0]  MEM_ByteEn;
   logic        MEM_Advance;
   logic        DataMem_Ready;
   logic [31:0] DataMem_ReadData;
   logic        MEM_Stall_Controller;
   logic        Mem_Req;
   logic [29:0] Mem_Addr;
   logic [3:0]  Mem_WE;
   logic [31:0] Mem_WriteData;
   logic        Mem_Ack;
   logic [31:0] Mem_ReadData;
   logic        Mem_Timeout;
   logic [1:0]  state_dbg;

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] exp_q[$];

   mem_arbiter #(.TIMEOUT(8)) dut (
      .clock                (clock),
      .reset                (reset),
      .InstMem_Read         (InstMem_Read),
      .InstMem_Address      (InstMem_Address),
      .IF_Advance           (IF_Advance),
      .InstMem_Ready        (InstMem_Ready),
      .InstMem_Data         (InstMem_Data),
      .MEM_MemRead          (MEM_MemRead),
      .MEM_MemWrite         (MEM_MemWrite),
      .MEM_Address          (MEM_Address),
      .MEM_WriteData        (MEM_WriteData),
      .MEM_ByteEn           (MEM_ByteEn),
      .MEM_Advance          (MEM_Advance),
      .DataMem_Ready        (DataMem_Ready),
      .DataMem_ReadData     (DataMem_ReadData),
      .MEM_Stall_Controller (MEM_Stall_Controller),
      .Mem_Req              (Mem_Req),
      .Mem_Addr             (Mem_Addr),
      .Mem_WE               (Mem_WE),
      .Mem_WriteData        (Mem_WriteData),
      .Mem_Ack              (Mem_Ack),
      .Mem_ReadData         (Mem_ReadData),
      .Mem_Timeout          (Mem_Timeout),
      .state_dbg            (state_dbg)
   );

   // Clock / time limit
   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: run time limit exceeded");
      $fatal(1, "time limit");
   end

   // Checking
   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_fetch(input string tag);
      logic [31:0] e;
      if (exp_q.size() == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s: got 0x%0h expected <empty queue>", tag, InstMem_Data);
      end else begin
         e = exp_q.pop_front();
         check_val(tag, {32'h0, InstMem_Data}, {32'h0, e});
      end
   endtask

   // Drivers
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Memory completes in the current cycle. On return, the bench sits in the
   // cycle after the ack edge.
   task automatic ack_now(input logic [31:0] data);
      Mem_Ack      = 1'b1;
      Mem_ReadData = data;
      tick();
      Mem_Ack      = 1'b0;
      Mem_ReadData = '0;
   endtask

   initial begin
      int pulses;
      reset           = 1'b0;
      InstMem_Read    = 1'b1;
      InstMem_Address = 30'h10;
      IF_Advance      = 1'b0;
      MEM_MemRead     = 1'b1;
      MEM_MemWrite    = 1'b0;
      MEM_Address     = 30'h40;
      MEM_WriteData   = '0;
      MEM_ByteEn      = '0;
      MEM_Advance     = 1'b0;
      Mem_Ack         = 1'b0;
      Mem_ReadData    = '0;

      // ---- Reset with requests high: everything reads 0
      tick();
      tick();
      check_val("rst_req",   Mem_Req, 0);
      check_val("rst_iready", InstMem_Ready, 0);
      check_val("rst_dready", DataMem_Ready, 0);
      check_val("rst_stall", MEM_Stall_Controller, 0);
      check_val("rst_idata", InstMem_Data, 0);
      check_val("rst_ddata", DataMem_ReadData, 0);
      check_val("rst_addr",  Mem_Addr, 0);
      check_val("rst_we",    Mem_WE, 0);
      check_val("rst_wdata", Mem_WriteData, 0);
      check_val("rst_tmo",   Mem_Timeout, 0);
      check_val("rst_state", state_dbg, 0);

      InstMem_Read = 1'b0;
      MEM_MemRead  = 1'b0;
      reset        = 1'b1;
      tick();

      // ---- Single fetch: ack 1 cycle after Mem_Req, ready at +3
      InstMem_Read    = 1'b1;
      InstMem_Address = 30'h10;
      #1;
      check_val("f1_req_n0", Mem_Req, 0);
      tick();
      check_val("f1_req_n1", Mem_Req, 1);
      check_val("f1_addr",   Mem_Addr, 30'h10);
      check_val("f1_we",     Mem_WE, 0);
      check_val("f1_state",  state_dbg, 2);
      tick();
      check_val("f1_ready_n2", InstMem_Ready, 0);
      exp_q.push_back(32'h2402000A);
      ack_now(32'h2402000A);
      check_val("f1_ready_n3", InstMem_Ready, 1);
      check_fetch("f1_data_n3");
      check_val("f1_req_n3", Mem_Req, 0);
      tick();
      check_val("f1_hold_ready", InstMem_Ready, 1);
      check_val("f1_hold_data",  InstMem_Data, 32'h2402000A);
      check_val("f1_hold_req",   Mem_Req, 0);
      IF_Advance   = 1'b1;
      InstMem_Read = 1'b0;
      tick();
      IF_Advance = 1'b0;
      check_val("f1_adv_ready", InstMem_Ready, 0);

      // ---- Simultaneous fetch + load: data wins, one IDLE gap, then fetch
      InstMem_Read    = 1'b1;
      InstMem_Address = 30'h10;
      MEM_MemRead     = 1'b1;
      MEM_Address     = 30'h40;
      #1;
      check_val("sim_stall_idle", MEM_Stall_Controller, 1);
      tick();
      check_val("sim_d_req",   Mem_Req, 1);
      check_val("sim_d_addr",  Mem_Addr, 30'h40);
      check_val("sim_d_state", state_dbg, 1);
      check_val("sim_d_stall", MEM_Stall_Controller, 1);
      ack_now(32'h11111111);
      check_val("sim_gap_req",   Mem_Req, 0);
      check_val("sim_gap_state", state_dbg, 0);
      check_val("sim_dready",    DataMem_Ready, 1);
      check_val("sim_ddata",     DataMem_ReadData, 32'h11111111);
      check_val("sim_stall_off", MEM_Stall_Controller, 0);
      tick();
      check_val("sim_i_req",  Mem_Req, 1);
      check_val("sim_i_addr", Mem_Addr, 30'h10);
      exp_q.push_back(32'h22222222);
      ack_now(32'h22222222);
      check_val("sim_iready", InstMem_Ready, 1);
      check_fetch("sim_idata");
      check_val("sim_dready_held", DataMem_Ready, 1);
      IF_Advance   = 1'b1;
      MEM_Advance  = 1'b1;
      InstMem_Read = 1'b0;
      MEM_MemRead  = 1'b0;
      tick();
      IF_Advance  = 1'b0;
      MEM_Advance = 1'b0;
      check_val("sim_adv_iready", InstMem_Ready, 0);
      check_val("sim_adv_dready", DataMem_Ready, 0);

      // ---- Store arrives during a fetch: no preemption, store follows
      InstMem_Read    = 1'b1;
      InstMem_Address = 30'h20;
      tick();
      MEM_MemWrite  = 1'b1;
      MEM_Address   = 30'h30;
      MEM_ByteEn    = 4'b0011;
      MEM_WriteData = 32'hDEADBEEF;
      #1;
      check_val("st_stall",     MEM_Stall_Controller, 1);
      check_val("st_inst_addr", Mem_Addr, 30'h20);
      tick();
      tick();
      tick();
      check_val("st_no_preempt_addr",  Mem_Addr, 30'h20);
      check_val("st_no_preempt_state", state_dbg, 2);
      exp_q.push_back(32'h33333333);
      ack_now(32'h33333333);
      check_val("st_iready", InstMem_Ready, 1);
      check_fetch("st_idata");
      check_val("st_gap_req", Mem_Req, 0);
      IF_Advance   = 1'b1;
      InstMem_Read = 1'b0;
      tick();
      IF_Advance = 1'b0;
      check_val("st_req",     Mem_Req, 1);
      check_val("st_addr",    Mem_Addr, 30'h30);
      check_val("st_we",      Mem_WE, 4'b0011);
      check_val("st_wdata",   Mem_WriteData, 32'hDEADBEEF);
      check_val("st_iready0", InstMem_Ready, 0);
      ack_now(32'h99999999);
      check_val("st_dready", DataMem_Ready, 1);
      check_val("st_ddata_unchanged", DataMem_ReadData, 32'h11111111);
      check_val("st_stall_off", MEM_Stall_Controller, 0);
      MEM_Advance  = 1'b1;
      MEM_MemWrite = 1'b0;
      tick();
      MEM_Advance = 1'b0;
      check_val("st_adv_dready", DataMem_Ready, 0);

      // ---- Flush: fetch dropped before ack, result discarded
      InstMem_Read    = 1'b1;
      InstMem_Address = 30'h50;
      tick();
      check_val("fl_addr", Mem_Addr, 30'h50);
      InstMem_Read = 1'b0;
      ack_now(32'h44444444);
      check_val("fl_iready", InstMem_Ready, 0);
      check_val("fl_idata_kept", InstMem_Data, 32'h33333333);
      check_val("fl_req", Mem_Req, 0);
      InstMem_Read    = 1'b1;
      InstMem_Address = 30'h54;
      tick();
      check_val("fl_next_req",  Mem_Req, 1);
      check_val("fl_next_addr", Mem_Addr, 30'h54);
      // Advance in the ack cycle: the ack wins, so ready is set
      IF_Advance = 1'b1;
      exp_q.push_back(32'h55555555);
      ack_now(32'h55555555);
      IF_Advance = 1'b0;
      check_val("fl_ackwins_ready", InstMem_Ready, 1);
      check_fetch("fl_ackwins_data");
      tick();
      check_val("fl_held_ready", InstMem_Ready, 1);

      // ---- Reset mid-transaction (in DATA)
      MEM_MemRead = 1'b1;
      MEM_Address = 30'h60;
      tick();
      check_val("mr_req",   Mem_Req, 1);
      check_val("mr_state", state_dbg, 1);
      reset = 1'b0;
      tick();
      check_val("mr_req0",    Mem_Req, 0);
      check_val("mr_state0",  state_dbg, 0);
      check_val("mr_iready0", InstMem_Ready, 0);
      check_val("mr_dready0", DataMem_Ready, 0);
      check_val("mr_stall0",  MEM_Stall_Controller, 0);
      check_val("mr_idata0",  InstMem_Data, 0);
      InstMem_Read = 1'b0;
      MEM_MemRead  = 1'b0;
      tick();
      reset = 1'b1;
      tick();

      // ---- Memory never acks a load
      MEM_MemRead = 1'b1;
      MEM_Address = 30'h70;
      tick();
      pulses = 0;
`ifdef MEMARB_TIMEOUT_EN
      for (int i = 0; i < 20; i++) begin
         if (Mem_Timeout) pulses++;
         tick();
      end
      check_val("to_pulses", pulses, 1);
      check_val("to_dready", DataMem_Ready, 1);
      check_val("to_ddata",  DataMem_ReadData, 0);
      check_val("to_req",    Mem_Req, 0);
`else
      for (int i = 0; i < 300; i++) begin
         if (Mem_Timeout) pulses++;
         tick();
      end
      check_val("nt_pulses", pulses, 0);
      check_val("nt_req",    Mem_Req, 1);
      check_val("nt_dready", DataMem_Ready, 0);
      check_val("nt_stall",  MEM_Stall_Controller, 1);
`endif
      MEM_MemRead = 1'b0;
      reset       = 1'b0;
      tick();
      check_val("end_req", Mem_Req, 0);
      reset = 1'b1;
      tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
